// File: rtl/puf_test_scheduler_pkg.sv
// Shared types for the PUF test scheduler: FSM state encoding and result memory layout.
package puf_test_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLKSW,
        ST_RUN,
        ST_SAMPLE,
        ST_STORE,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam int COUNT_W = 8;

    // Results are laid out phase-major: each phase owns a block of `stride` consecutive words.
    function automatic int result_addr(input int phase, input int idx, input int stride);
        return phase * stride + idx;
    endfunction

endpackage

// File: rtl/puf_test_scheduler_pass.sv
// Per-test saturating pass counters, summed over the rounds of one phase.
module pass_accumulator #(
    parameter int N_TESTS = 8
) (
    input  logic                   clk_1,
    input  logic                   rst,
    input  logic                   add_en,
    input  logic                   clr,
    input  logic [N_TESTS-1:0]     pass_in,
    output logic [N_TESTS*8-1:0]   counts
);

    always_ff @(posedge clk_1) begin
        if (rst || clr) begin
            counts <= '0;
        end else if (add_en) begin
            for (int i = 0; i < N_TESTS; i++) begin
                if (pass_in[i] && (counts[i*8 +: 8] != 8'hFF)) begin
                    counts[i*8 +: 8] <= counts[i*8 +: 8] + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/puf_test_scheduler.sv
// Multi-phase sequencer: clock select/settle, bit-counted NIST rounds, pass-count
// accumulation and write-out of N_TESTS counts per phase to result memory.
//
// state  | meaning
// IDLE   | waiting for start
// CLKSW  | test clock selected, NIST block held in clear for SETTLE cycles
// RUN    | counting response bits of the current round
// SAMPLE | accumulating the round's pass flags
// STORE  | writing pass counts to memory, one per accepted write
// NEXT   | clearing accumulators, advancing phase
// DONE   | all phases written; start restarts at phase 0
module puf_test_scheduler
    import puf_test_scheduler_pkg::*;
#(
    parameter int N_PHASE        = 3,
    parameter int BITS_PER_ROUND = 20000,
    parameter int ROUNDS         = 255,
    parameter int N_TESTS        = 8,
    parameter int ADDR_W         = 13,
    parameter int SETTLE         = 4
) (
    input  logic               clk_1,
    input  logic               rst,
    input  logic               start,
    input  logic               bit_valid,
    input  logic [N_TESTS-1:0] test_result,
    input  logic               mem_ready,
    output logic               busy,
    output logic               done,
    output logic [1:0]         phase_id,
    output logic               sel_clk_test,
    output logic               nist_clear,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_waddr,
    output logic [7:0]         mem_din
);

    localparam int BIT_W = (BITS_PER_ROUND > 2) ? $clog2(BITS_PER_ROUND) : 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int IDX_W = (N_TESTS > 1) ? $clog2(N_TESTS) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(BITS_PER_ROUND - 1);
    localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SETTLE - 1);
    localparam logic [7:0]       ROUND_LAST = 8'(ROUNDS);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_TESTS - 1);
    localparam logic [1:0]       PHASE_LAST = 2'(N_PHASE - 1);

    state_t                 state, state_nxt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [SET_W-1:0]       settle_cnt;
    logic [7:0]             round_cnt;
    logic [IDX_W-1:0]       idx;
    logic [N_TESTS*8-1:0]   counts;
    logic                   start_ok;

    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_CLKSW;
            ST_CLKSW:         if (settle_cnt == '0) state_nxt = ST_RUN;
            ST_RUN:           if (bit_valid && (bit_cnt == BIT_LAST)) state_nxt = ST_SAMPLE;
            ST_SAMPLE:        state_nxt = ((round_cnt + 8'd1) == ROUND_LAST) ? ST_STORE : ST_RUN;
            ST_STORE:         if (mem_ready && (idx == IDX_LAST)) state_nxt = ST_NEXT;
            ST_NEXT:          state_nxt = (phase_id == PHASE_LAST) ? ST_DONE : ST_CLKSW;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            settle_cnt   <= '0;
            round_cnt    <= '0;
            idx          <= '0;
            phase_id     <= '0;
            sel_clk_test <= 1'b0;
        end else begin
            state <= state_nxt;

            // The clock select only moves together with entry into CLKSW.
            if (start_ok) begin
                phase_id     <= '0;
                sel_clk_test <= 1'b0;
                settle_cnt   <= SET_LAST;
            end else if ((state == ST_NEXT) && (phase_id != PHASE_LAST)) begin
                phase_id     <= phase_id + 2'd1;
                sel_clk_test <= 1'b1;
                settle_cnt   <= SET_LAST;
            end else if ((state == ST_CLKSW) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            if ((state == ST_RUN) && bit_valid) begin
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end

            if (state == ST_SAMPLE) begin
                round_cnt <= round_cnt + 8'd1;
            end else if (state == ST_NEXT) begin
                round_cnt <= '0;
            end

            if ((state == ST_STORE) && mem_ready) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    pass_accumulator #(
        .N_TESTS (N_TESTS)
    ) u_pass_acc (
        .clk_1   (clk_1),
        .rst     (rst),
        .add_en  (state == ST_SAMPLE),
        .clr     (state == ST_NEXT),
        .pass_in (test_result),
        .counts  (counts)
    );

    assign busy       = (state != ST_IDLE) && (state != ST_DONE);
    assign done       = (state == ST_DONE);
    assign nist_clear = (state == ST_CLKSW);
    assign mem_we     = (state == ST_STORE);
    assign mem_waddr  = ADDR_W'(result_addr(int'(phase_id), int'(idx), N_TESTS));
    assign mem_din    = counts[idx*8 +: 8];

endmodule

// File: tb/tb_puf_test_scheduler.sv
// Directed bench for puf_test_scheduler: single-phase scenarios on one instance,
// three-phase clock/address sequencing on a second; writes checked against a queue.
module tb_puf_test_scheduler;

    localparam int NT     = 8;
    localparam int SETTLE = 4;
    localparam int NB     = 4;

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  din;
    } wr_t;

    logic        clk_1 = 1'b0;
    logic        rst, start, start3, bit_valid, mem_ready, use3;
    logic [7:0]  test_result;

    logic        busy1, done1, sel1, nist1, we1;
    logic [1:0]  phase1;
    logic [12:0] waddr1;
    logic [7:0]  din1;
    logic        busy3, done3, sel3, nist3, we3;
    logic [1:0]  phase3;
    logic [12:0] waddr3;
    logic [7:0]  din3;

    logic        cur_busy, cur_done, cur_sel, cur_nist, cur_we;
    logic [1:0]  cur_phase;
    logic [12:0] cur_waddr;
    logic [7:0]  cur_din;

    int  checks = 0;
    int  errors = 0;
    int  acc[NT];
    wr_t exp_q[$];

    always #5 clk_1 = ~clk_1;

    puf_test_scheduler #(
        .N_PHASE(1), .BITS_PER_ROUND(NB), .ROUNDS(2), .N_TESTS(NT), .ADDR_W(13), .SETTLE(SETTLE)
    ) dut (
        .clk_1(clk_1), .rst(rst), .start(start), .bit_valid(bit_valid),
        .test_result(test_result), .mem_ready(mem_ready), .busy(busy1), .done(done1),
        .phase_id(phase1), .sel_clk_test(sel1), .nist_clear(nist1), .mem_we(we1),
        .mem_waddr(waddr1), .mem_din(din1)
    );

    puf_test_scheduler #(
        .N_PHASE(3), .BITS_PER_ROUND(NB), .ROUNDS(2), .N_TESTS(NT), .ADDR_W(13), .SETTLE(SETTLE)
    ) dut3 (
        .clk_1(clk_1), .rst(rst), .start(start3), .bit_valid(bit_valid),
        .test_result(test_result), .mem_ready(mem_ready), .busy(busy3), .done(done3),
        .phase_id(phase3), .sel_clk_test(sel3), .nist_clear(nist3), .mem_we(we3),
        .mem_waddr(waddr3), .mem_din(din3)
    );

    assign cur_busy  = use3 ? busy3  : busy1;
    assign cur_done  = use3 ? done3  : done1;
    assign cur_sel   = use3 ? sel3   : sel1;
    assign cur_nist  = use3 ? nist3  : nist1;
    assign cur_we    = use3 ? we3    : we1;
    assign cur_phase = use3 ? phase3 : phase1;
    assign cur_waddr = use3 ? waddr3 : waddr1;
    assign cur_din   = use3 ? din3   : din1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A write is accepted on the rising edge where mem_we && mem_ready; look half a cycle earlier.
    always @(negedge clk_1) begin
        wr_t e;
        if ((we1 || we3) && mem_ready) begin
            check("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mem_waddr", we3 ? waddr3 : waddr1, e.addr);
                check("mem_din", we3 ? din3 : din1, e.din);
            end
        end
    end

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NT; i++) acc[i] = 0;
    endtask

    task automatic model_add(input logic [7:0] tr);
        for (int i = 0; i < NT; i++) begin
            if (tr[i] && acc[i] < 255) acc[i]++;
        end
    endtask

    task automatic push_phase(input int p);
        wr_t e;
        for (int i = 0; i < NT; i++) begin
            e.addr = 13'(p * NT + i);
            e.din  = 8'(acc[i]);
            exp_q.push_back(e);
        end
    endtask

    task automatic settle_checks(input int p);
        for (int s = 0; s < SETTLE; s++) begin
            check("nist_clear_settle", cur_nist, 1);
            check("sel_clk_test", cur_sel, 32'(p != 0));
            check("phase_id", cur_phase, p);
            check("busy_settle", cur_busy, 1);
            tick();
        end
        check("nist_clear_end", cur_nist, 0);
    endtask

    task automatic do_start();
        if (use3) start3 = 1'b1;
        else start = 1'b1;
        tick();
        start  = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic run_round(input logic [7:0] tr);
        test_result = tr;
        bit_valid   = 1'b1;
        repeat (NB) tick();
        bit_valid = 1'b0;
        tick();
        model_add(tr);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!cur_done && n < 60) begin
            tick();
            n++;
        end
        check("done_reached", cur_done, 1);
        check("busy_at_done", cur_busy, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        use3 = 1'b0; rst = 1'b1; start = 1'b0; start3 = 1'b0;
        bit_valid = 1'b0; mem_ready = 1'b1; test_result = 8'h00;
        tick(); tick();
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_phase", phase1, 0);
        check("rst_sel", sel1, 0);
        check("rst_nist", nist1, 0);
        check("rst_we", we1, 0);
        check("rst_waddr", waddr1, 0);
        check("rst_din", din1, 0);
        check("rst_busy3", busy3, 0);
        check("rst_sel3", sel3, 0);
        rst = 1'b0;
        tick();

        // 1: bit_valid held high throughout, all tests pass every round
        model_clear();
        model_add(8'hFF);
        model_add(8'hFF);
        push_phase(0);
        test_result = 8'hFF;
        bit_valid   = 1'b1;
        do_start();
        settle_checks(0);
        repeat (9) tick();
        check("store_not_early", cur_we, 0);
        tick();
        check("store_entry", cur_we, 1);
        wait_done();
        bit_valid = 1'b0;
        check("done_phase", cur_phase, 0);
        check("done_sel", cur_sel, 0);

        // 2: alternating halves; start during RUN must be ignored
        model_clear();
        do_start();
        settle_checks(0);
        run_round(8'h0F);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_busy", cur_busy, 1);
        check("start_ignored_nist", cur_nist, 0);
        run_round(8'hF0);
        push_phase(0);
        wait_done();

        // 3: memory back-pressure mid-store
        model_clear();
        do_start();
        settle_checks(0);
        run_round(8'hA5);
        run_round(8'h3C);
        push_phase(0);
        tick(); tick();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_we", cur_we, 1);
            check("stall_waddr", cur_waddr, 2);
            check("stall_din", cur_din, acc[2]);
            tick();
        end
        check("stall_waddr_end", cur_waddr, 2);
        mem_ready = 1'b1;
        wait_done();

        // 4: reset in RUN of round 2, then a fresh run
        model_clear();
        do_start();
        settle_checks(0);
        test_result = 8'hFF;
        bit_valid   = 1'b1;
        repeat (NB) tick();
        bit_valid = 1'b0;
        tick();
        bit_valid = 1'b1;
        tick(); tick();
        bit_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", cur_busy, 0);
        check("midrst_done", cur_done, 0);
        check("midrst_we", cur_we, 0);
        check("midrst_nist", cur_nist, 0);
        tick();
        model_clear();
        do_start();
        settle_checks(0);
        run_round(8'h81);
        run_round(8'h18);
        push_phase(0);
        wait_done();

        // 5: a bit during SAMPLE is discarded
        model_clear();
        do_start();
        settle_checks(0);
        test_result = 8'h77;
        bit_valid   = 1'b1;
        repeat (NB) tick();
        tick();
        model_add(8'h77);
        test_result = 8'hEE;
        repeat (NB - 1) tick();
        bit_valid = 1'b0;
        repeat (3) tick();
        check("sample_bit_not_counted", cur_we, 0);
        check("sample_busy", cur_busy, 1);
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        tick();
        model_add(8'hEE);
        push_phase(0);
        check("round2_store", cur_we, 1);
        wait_done();

        // 6: three phases on the second instance
        use3 = 1'b1;
        do_start();
        for (int p = 0; p < 3; p++) begin
            int n;
            if (p > 0) begin
                n = 0;
                while (!cur_nist && n < 30) begin
                    tick();
                    n++;
                end
                check("clksw_reached", cur_nist, 1);
            end
            settle_checks(p);
            model_clear();
            run_round(8'hFF);
            check("sel_stable_run", cur_sel, 32'(p != 0));
            run_round(8'(8'h11 << p));
            push_phase(p);
        end
        wait_done();
        check("done3_phase", cur_phase, 2);
        check("done3_sel", cur_sel, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
